// File: rtl/fetch_unit_q_if.sv
// Fetch-unit bus: instruction-memory port, redirect input, output handshake with decoded fields, LED display.
// master = fetch unit, slave = surrounding pipeline / memory.
interface fetch_unit_q_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_pc;
    logic [5:0]        op_code;
    logic [4:0]        rs_addr;
    logic [4:0]        rt_addr;
    logic [4:0]        rd_addr;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [1:0]        disp_sel;
    logic [7:0]        LED;

    modport master (
        output imem_en, imem_addr,
        input  imem_rdata,
        input  redirect_valid, redirect_pc,
        output out_valid, out_inst, out_pc,
        input  out_ready,
        output op_code, rs_addr, rt_addr, rd_addr, shamt, funct,
        input  disp_sel,
        output LED
    );

    modport slave (
        input  imem_en, imem_addr,
        output imem_rdata,
        output redirect_valid, redirect_pc,
        input  out_valid, out_inst, out_pc,
        output out_ready,
        input  op_code, rs_addr, rt_addr, rd_addr, shamt, funct,
        output disp_sel,
        input  LED
    );
endinterface

// File: rtl/fetch_unit_q.sv
// MIPS instruction-fetch stage: PC, 1-cycle-latency imem port, credit-based prefetch FIFO, redirect flush.
// Optional byte display on LED enabled by defining FETCH_LED_DISP_EN.
module fetch_unit_q #(
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int unsigned       PC_STEP    = 4,
    parameter int unsigned       FIFO_DEPTH = 4
) (
    input logic            clk,
    input logic            rst,
    fetch_unit_q_if.master bus
);
    localparam int unsigned       PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned       CNT_W   = PTR_W + 1;
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);
    localparam logic [CNT_W:0]    DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] tag;
    logic              pending;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [31:0]       inst_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] pc_mem   [FIFO_DEPTH];

    logic              issue;
    logic              push;
    logic              pop;
    logic              head_valid;
    logic [CNT_W:0]    credits_used;

    // An in-flight fetch already owns a FIFO slot; a same-cycle pop is not counted as a free slot.
    always_comb begin
        credits_used = {1'b0, count} + {{CNT_W{1'b0}}, pending};
        issue        = !rst && !bus.redirect_valid && (credits_used < DEPTH_C);
        head_valid   = (count != '0);
        pop          = head_valid && bus.out_ready;
        push         = pending;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            tag     <= '0;
            pending <= 1'b0;
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
        end else if (bus.redirect_valid) begin
            pc      <= bus.redirect_pc;
            pending <= 1'b0;
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
        end else begin
            if (issue) begin
                pc  <= pc + STEP;
                tag <= pc;
            end
            pending <= issue;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: FIFO storage has no reset; count and pointers alone decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push && !rst && !bus.redirect_valid) begin
            inst_mem[wr_ptr] <= bus.imem_rdata;
            pc_mem[wr_ptr]   <= tag;
        end
    end

    assign bus.imem_en   = issue;
    assign bus.imem_addr = pc;
    assign bus.out_valid = head_valid;
    assign bus.out_inst  = head_valid ? inst_mem[rd_ptr] : 32'h0;
    assign bus.out_pc    = head_valid ? pc_mem[rd_ptr] : '0;

    assign bus.op_code = bus.out_inst[31:26];
    assign bus.rs_addr = bus.out_inst[25:21];
    assign bus.rt_addr = bus.out_inst[20:16];
    assign bus.rd_addr = bus.out_inst[15:11];
    assign bus.shamt   = bus.out_inst[10:6];
    assign bus.funct   = bus.out_inst[5:0];

`ifdef FETCH_LED_DISP_EN
    always_comb begin
        // NOTE: LED gets a default before the case so no path leaves it unassigned (no latch).
        bus.LED = 8'h00;
        if (head_valid) begin
            case (bus.disp_sel)
                2'd0:    bus.LED = bus.out_inst[7:0];
                2'd1:    bus.LED = bus.out_inst[15:8];
                2'd2:    bus.LED = bus.out_inst[23:16];
                default: bus.LED = bus.out_inst[31:24];
            endcase
        end
    end
`else
    logic unused_disp_sel;
    assign unused_disp_sel = ^bus.disp_sel;
    assign bus.LED         = 8'h00;
`endif
endmodule

// File: tb/tb_fetch_unit_q.sv
// Self-checking bench for fetch_unit_q: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized ready/redirect/reset traffic.
`timescale 1ns/1ps
module tb_fetch_unit_q;
    localparam int          ADDR_W = 32;
    localparam int          DEPTH  = 4;
    localparam int          STEP   = 4;
    localparam logic [31:0] RST_PC = 32'h0;
    localparam logic [31:0] LED_PC = 32'h0A61_C001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_q_if #(.ADDR_W(ADDR_W)) bus ();

    fetch_unit_q #(
        .ADDR_W(ADDR_W), .RESET_PC(RST_PC), .PC_STEP(STEP), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {addr[29:0], 2'b00} ^ 32'hA5A5_0000;
    endfunction

    // Instruction memory: word for the address requested in the previous cycle, garbage otherwise.
    always @(posedge clk) begin
        if (bus.imem_en === 1'b1) bus.imem_rdata <= mem_word(bus.imem_addr);
        else                      bus.imem_rdata <= $urandom;
    end

    // Reference model: FIFO of fetched addresses plus at most one outstanding request.
    logic [31:0] q_pc[$];
    bit          infl    = 1'b0;
    logic [31:0] infl_pc = '0;
    logic [31:0] m_pc    = RST_PC;
    int          occ     = 0;

    initial begin
        logic        exp_valid, exp_en;
        logic [31:0] exp_pc, exp_inst;
        logic [7:0]  exp_led;
        @(posedge clk);
        forever begin
            @(negedge clk);
            exp_valid = (q_pc.size() != 0);
            exp_pc    = exp_valid ? q_pc[0] : 32'h0;
            exp_inst  = exp_valid ? mem_word(q_pc[0]) : 32'h0;
            exp_en    = !rst && !bus.redirect_valid && ((q_pc.size() + int'(infl)) < DEPTH);
`ifdef FETCH_LED_DISP_EN
            exp_led = exp_valid ? exp_inst[8*bus.disp_sel +: 8] : 8'h00;
`else
            exp_led = 8'h00;
`endif
            check("imem_en",   32'(bus.imem_en),   32'(exp_en));
            check("imem_addr", bus.imem_addr,      m_pc);
            check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
            check("out_pc",    bus.out_pc,         exp_pc);
            check("out_inst",  bus.out_inst,       exp_inst);
            check("LED",       32'(bus.LED),       32'(exp_led));
            if (exp_valid) begin
                check("op_code", 32'(bus.op_code), 32'(exp_inst[31:26]));
                check("rs_addr", 32'(bus.rs_addr), 32'(exp_inst[25:21]));
                check("rt_addr", 32'(bus.rt_addr), 32'(exp_inst[20:16]));
                check("rd_addr", 32'(bus.rd_addr), 32'(exp_inst[15:11]));
                check("shamt",   32'(bus.shamt),   32'(exp_inst[10:6]));
                check("funct",   32'(bus.funct),   32'(exp_inst[5:0]));
            end
            // Occupancy seen from DUT outputs alone: issued-but-not-popped must never exceed the FIFO.
            if (rst || bus.redirect_valid) occ = 0;
            else begin
                occ += int'(bus.imem_en === 1'b1) - int'(bus.out_valid === 1'b1 && bus.out_ready);
                check("no_overflow", 32'(occ <= DEPTH), 32'd1);
            end
            // Advance the model to the state after the coming rising edge.
            if (rst) begin
                q_pc.delete(); infl = 1'b0; m_pc = RST_PC;
            end else if (bus.redirect_valid) begin
                q_pc.delete(); infl = 1'b0; m_pc = bus.redirect_pc;
            end else begin
                if (exp_valid && bus.out_ready) void'(q_pc.pop_front());
                if (infl) q_pc.push_back(infl_pc);
                infl    = exp_en;
                infl_pc = m_pc;
                if (exp_en) m_pc = m_pc + STEP;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    // Directed scenarios and random traffic.
    initial begin
        int          n_iss, first_resume, found;
        logic [7:0]  led_tbl [4];
        led_tbl = '{8'h04, 8'h00, 8'h22, 8'h8C};
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.disp_sel       = 2'd0;

        // Streaming from reset: 2 reset edges, then first fetch, output two cycles later.
        @(negedge clk);
        check("rst_imem_en",   32'(bus.imem_en),   32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("a_first_en",   32'(bus.imem_en), 32'd1);
        check("a_first_addr", bus.imem_addr,    32'h0);
        tick();
        @(negedge clk);
        check("a_lat_valid", 32'(bus.out_valid), 32'd0);
        tick();
        @(negedge clk);
        check("a_valid", 32'(bus.out_valid), 32'd1);
        check("a_pc0",   bus.out_pc,         32'h0);
        check("a_inst0", bus.out_inst,       32'hA5A5_0000);
        tick();
        @(negedge clk);
        check("a_pc1",   bus.out_pc,   32'h4);
        check("a_inst1", bus.out_inst, 32'hA5A5_0010);
        repeat (6) tick();

        // Stalled consumer: exactly FIFO_DEPTH fetches, then drain and resume.
        rst = 1'b1; bus.out_ready = 1'b0;
        tick();
        rst = 1'b0;
        n_iss = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.imem_en === 1'b1) n_iss++;
            tick();
        end
        @(negedge clk);
        check("b_issue_count", 32'(n_iss),        32'd4);
        check("b_hold_pc",     bus.out_pc,        32'h0);
        check("b_en_off",      32'(bus.imem_en),  32'd0);
        check("b_next_addr",   bus.imem_addr,     32'h10);
        tick();
        bus.out_ready = 1'b1;
        first_resume = -1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("b_drain_pc", bus.out_pc, 32'(4 * i));
            if (first_resume < 0 && bus.imem_en === 1'b1) begin
                first_resume = i;
                check("b_resume_addr", bus.imem_addr, 32'h10);
            end
            tick();
        end
        check("b_resume_gap", 32'(first_resume >= 0 && first_resume <= 2), 32'd1);
        repeat (3) tick();

        // Redirect while streaming.
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h40;
        @(negedge clk);
        check("c_no_issue_r", 32'(bus.imem_en), 32'd0);
        tick();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("c_valid_r1", 32'(bus.out_valid), 32'd0);
        check("c_addr_r1",  bus.imem_addr,      32'h40);
        tick();
        @(negedge clk);
        check("c_valid_r2", 32'(bus.out_valid), 32'd0);
        tick();
        @(negedge clk);
        check("c_pc_r3", bus.out_pc, 32'h40);
        tick();
        @(negedge clk);
        check("c_pc_r4", bus.out_pc, 32'h44);
        tick();

        // Redirect with 3 buffered + 1 in flight (all credits used), then LED/field pinning.
        rst = 1'b1; bus.out_ready = 1'b0;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("d_last_issue", bus.imem_addr, 32'hC);
        tick();
        bus.redirect_valid = 1'b1; bus.redirect_pc = LED_PC;
        @(negedge clk);
        check("d_full_valid", 32'(bus.out_valid), 32'd1);
        check("d_full_en",    32'(bus.imem_en),   32'd0);
        tick();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("d_flushed", 32'(bus.out_valid), 32'd0);
        repeat (2) tick();
        @(negedge clk);
        check("d_head_pc",   bus.out_pc,         LED_PC);
        check("d_head_inst", bus.out_inst,       32'h8C22_0004);
        check("d_op_code",   32'(bus.op_code),   32'h23);
        check("d_rs",        32'(bus.rs_addr),   32'd1);
        check("d_rt",        32'(bus.rt_addr),   32'd2);
        check("d_funct",     32'(bus.funct),     32'd4);
        for (int s = 0; s < 4; s++) begin
            tick();
            bus.disp_sel = 2'(s);
            @(negedge clk);
`ifdef FETCH_LED_DISP_EN
            check("d_led", 32'(bus.LED), 32'(led_tbl[s]));
`else
            check("d_led", 32'(bus.LED), 32'd0);
`endif
        end
        tick();

        // Single-cycle reset mid-stream when PC reaches 0x20.
        bus.out_ready = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (bus.imem_addr === 32'h20) found = 1;
        end
        check("e_reach_pc20", 32'(found), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("e_rst_en", 32'(bus.imem_en), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("e_valid",  32'(bus.out_valid), 32'd0);
        check("e_addr",   bus.imem_addr,      RST_PC);
        check("e_en",     32'(bus.imem_en),   32'd1);
        repeat (2) tick();
        @(negedge clk);
        check("e_first_valid", 32'(bus.out_valid), 32'd1);
        check("e_first_pc",    bus.out_pc,         32'h0);
        tick();

        // Random traffic, including PC wraparound.
        for (int i = 0; i < 800; i++) begin
            bus.out_ready      = (i % 100 < 20) ? 1'b0 : ($urandom_range(0, 3) != 0);
            bus.disp_sel       = 2'($urandom_range(0, 3));
            bus.redirect_valid = ($urandom_range(0, 19) == 0);
            bus.redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8
                                                             : {22'($urandom), 8'($urandom_range(0, 255)), 2'b00};
            rst                = ($urandom_range(0, 99) == 0);
            tick();
        end
        bus.redirect_valid = 1'b0; rst = 1'b0;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
